pipelined_controller: RTL and testbench
=======================================

Name: pipelined_controller

Overview:
- Control unit for the 5-stage (F/D/E/M/W) RV32I core; successor to the single-cycle controller.
- Decodes the instruction in D (same opcode/ALU encodings as the single-cycle core) and carries the control bundle through its own D/E, E/M and M/W registers.
- Contains the hazard unit: forwarding selects, load-use stall, and branch/jump flush.
- Forwarding vs. stall-only mode is set by a parameter.

Parameters:
- ENABLE_FORWARDING, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = resolve every RAW hazard by stalling.
- REG_ADDR_W, 5, register index width (4 for RV32E).
- ALU_OP_W, 5, alu_op width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- inst_d  in  32  instruction held in the IF/ID register.
- valid_d  in  1  inst_d is real (0 = fetch bubble).
- br_taken_e  in  1  branch comparator result for the instruction in E.
- imm_src_d  out  3  immediate type for D (000 I, 001 S, 010 B, 011 J, 100 U).
- illegal_d  out  1  unknown opcode while valid_d=1.
- alu_op_e  out  ALU_OP_W  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 LUI10.
- sel_a_e  out  1  1 = rs1, 0 = PC.
- sel_b_e  out  1  1 = immediate, 0 = rs2.
- fwd_a_e, fwd_b_e  out  2 each  00 = regfile, 01 = W result, 10 = M ALU result.
- pc_src_e  out  1  redirect PC to the E target.
- mem_wr_m  out  1  store enable.
- funct3_m  out  3  load/store size.
- reg_wr_w  out  1  register file write enable.
- wb_sel_w  out  2  00 = PC+4, 01 = ALU, 10 = memory.
- rd_w  out  REG_ADDR_W  write-back register.
- stall_f, stall_d  out  1 each  hold the PC and the IF/ID register.
- flush_d  out  1  clear IF/ID.

Behaviour:
- Decode (combinational in D):
  - Every control field defaults to 0, so no latches.
  - Unknown opcode, or valid_d=0, produces a bubble: reg_wr=0, mem_wr=0, branch=0, jump=0, valid=0. illegal_d = valid_d & unknown opcode.
  - Opcode mapping is as in the single-cycle controller.
  - JAL and JALR set jump. B-type sets branch and alu_op=ADD.
- Source use:
  - rs1 is used by R, I-ALU, load, store, branch and JALR.
  - rs2 is used by R, store and branch.
  - LUI, AUIPC and JAL use neither source and never cause a stall.
- Pipeline registers:
  - Each stage register holds valid, control, rd, rs1 and rs2, and advances every cycle.
  - D->E loads a bubble when flush_e (internal) = 1.
  - Latency: an instruction in D in cycle n drives E outputs in n+1, M outputs in n+2, W outputs in n+3.
- Reset: every stage valid=0 and every output 0, including stall_f, stall_d, flush_d, fwd_* and pc_src_e.
- Forwarding (ENABLE_FORWARDING=1):
  - fwd_a_e=10 if valid_m & reg_wr_m & rd_m≠0 & rd_m==rs1_e.
  - Otherwise fwd_a_e=01 if valid_w & reg_wr_w & rd_w≠0 & rd_w==rs1_e.
  - Otherwise fwd_a_e=00. M takes priority over W.
  - fwd_b_e uses the same rules with rs2_e.
  - When ENABLE_FORWARDING=0, fwd_* are tied to 00.
- Load-use stall (ENABLE_FORWARDING=1): stall when E holds a valid load with rd_e≠0 and rd_e equals a used source of D. The stall cycle does stall_f=1, stall_d=1, flush_e=1, lasting exactly one cycle per load.
- Stall-only mode (ENABLE_FORWARDING=0):
  - Stall while any of E, M, W holds a valid writer with rd≠0 matching a used D source.
  - The register file is not write-through, so a W match also stalls.
- Control hazard:
  - pc_src_e = valid_e & (jump_e | (branch_e & br_taken_e)).
  - In the same cycle: flush_d=1 and flush_e=1. The next edge squashes the D instruction and bubbles E.
- Priorities: flush beats stall. When pc_src_e=1, stall_f=0 and stall_d=0 even if a load-use match exists.
- Register x0 is never a forwarding or stall source.
- rst asserted mid-stream: all in-flight instructions are discarded at the next edge. No write-back or store fires after the reset edge.

Test Plan:
1. Reset: hold rst 2 cycles with arbitrary inst_d -> every output 0, reg_wr_w=0 for 3 cycles after release with valid_d=0.
2. Forward from M: add x3,x1,x2 (0x002081B3) then sub x4,x3,x1 (0x40118233) -> with sub in E: fwd_a_e=10, fwd_b_e=00, alu_op_e=1. Add NOP before sub -> fwd_a_e=01.
3. Load-use: lw x5,0(x1) (0x0000A283) then add x6,x5,x0 (0x00028333) -> exactly one cycle with stall_f=stall_d=1 and flush_e=1, then fwd_a_e=01 with add in E.
4. Taken branch with flush priority: beq in E with br_taken_e=1 while D holds a load-use consumer -> pc_src_e=1, flush_d=1, stall_f=0, and the two squashed slots give reg_wr_w=0 and mem_wr_m=0. With br_taken_e=0 -> no flush.
5. x0 and illegal: addi x0,x1,5 then add x7,x0,x0 -> fwd_*=00, no stall. inst_d=0xFFFFFFFF -> illegal_d=1, bubble reaches W with reg_wr_w=0.
6. ENABLE_FORWARDING=0 instance, sequence from scenario 2 -> stall_d=1 for 3 consecutive cycles, sub enters E the cycle after add leaves W, fwd_*=00 throughout.

Source files
------------

// File: rtl/pipelined_controller.sv
// Control unit for the 5-stage RV32I pipeline: D-stage decode, D/E, E/M and M/W control
// registers, and the hazard unit (forwarding selects, RAW stalls, branch/jump flush).
`timescale 1ns / 1ps

module pipelined_controller #(
   parameter bit          ENABLE_FORWARDING = 1'b1,
   parameter int unsigned REG_ADDR_W        = 5,
   parameter int unsigned ALU_OP_W          = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           inst_d,
   input  logic                  valid_d,
   input  logic                  br_taken_e,
   output logic [2:0]            imm_src_d,
   output logic                  illegal_d,
   output logic [ALU_OP_W-1:0]   alu_op_e,
   output logic                  sel_a_e,
   output logic                  sel_b_e,
   output logic [1:0]            fwd_a_e,
   output logic [1:0]            fwd_b_e,
   output logic                  pc_src_e,
   output logic                  mem_wr_m,
   output logic [2:0]            funct3_m,
   output logic                  reg_wr_w,
   output logic [1:0]            wb_sel_w,
   output logic [REG_ADDR_W-1:0] rd_w,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   typedef struct packed {
      logic                  valid;
      logic                  reg_wr;
      logic                  mem_wr;
      logic                  branch;
      logic                  jump;
      logic                  is_load;
      logic                  sel_a;
      logic                  sel_b;
      logic [1:0]            wb_sel;
      logic [2:0]            funct3;
      logic [ALU_OP_W-1:0]   alu_op;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } ctrl_t;

   typedef struct packed {
      logic                  valid;
      logic                  reg_wr;
      logic                  mem_wr;
      logic [1:0]            wb_sel;
      logic [2:0]            funct3;
      logic [REG_ADDR_W-1:0] rd;
   } mctrl_t;

   typedef struct packed {
      logic                  valid;
      logic                  reg_wr;
      logic [1:0]            wb_sel;
      logic [REG_ADDR_W-1:0] rd;
   } wctrl_t;

   function automatic logic [ALU_OP_W-1:0] alu_dec(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_OP_W'(1) : ALU_OP_W'(0);
         3'b001:  return ALU_OP_W'(2);
         3'b010:  return ALU_OP_W'(3);
         3'b011:  return ALU_OP_W'(4);
         3'b100:  return ALU_OP_W'(5);
         3'b101:  return alt ? ALU_OP_W'(7) : ALU_OP_W'(6);
         3'b110:  return ALU_OP_W'(8);
         default: return ALU_OP_W'(9);
      endcase
   endfunction

   // Source fields are zeroed when unused, so an unused field can never match a nonzero rd.
   function automatic logic hits(input logic v, input logic wr, input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] rs1,
                                 input logic [REG_ADDR_W-1:0] rs2);
      return v & wr & (rd != '0) & ((rd == rs1) | (rd == rs2));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input mctrl_t m,
                                          input wctrl_t w);
      if (m.valid && m.reg_wr && m.rd != '0 && m.rd == rs) return 2'b10;
      if (w.valid && w.reg_wr && w.rd != '0 && w.rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   ctrl_t      ctrl_d, ctrl_e;
   mctrl_t     ctrl_m;
   wctrl_t     ctrl_w;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic       known, use_rs1, use_rs2, live_d;
   logic       load_use, raw_any, stall_raw, flush_e;
   logic       unused_inst;

   assign opcode      = inst_d[6:0];
   assign f3          = inst_d[14:12];
   assign live_d      = valid_d & ~rst;
   assign unused_inst = ^inst_d;

   always_comb begin
      ctrl_d    = '0;
      imm_src_d = 3'b000;
      known     = 1'b1;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      case (opcode)
         OpR: begin
            ctrl_d.reg_wr = 1'b1; ctrl_d.sel_a = 1'b1; ctrl_d.wb_sel = 2'b01;
            ctrl_d.alu_op = alu_dec(f3, inst_d[30]);
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OpI: begin
            ctrl_d.reg_wr = 1'b1; ctrl_d.sel_a = 1'b1; ctrl_d.sel_b = 1'b1; ctrl_d.wb_sel = 2'b01;
            ctrl_d.alu_op = alu_dec(f3, inst_d[30] & (f3 == 3'b101));
            use_rs1 = 1'b1;
         end
         OpLoad: begin
            ctrl_d.reg_wr = 1'b1; ctrl_d.is_load = 1'b1; ctrl_d.sel_a = 1'b1; ctrl_d.sel_b = 1'b1;
            ctrl_d.wb_sel = 2'b10; ctrl_d.funct3 = f3;
            use_rs1 = 1'b1;
         end
         OpStore: begin
            ctrl_d.mem_wr = 1'b1; ctrl_d.sel_a = 1'b1; ctrl_d.sel_b = 1'b1; ctrl_d.funct3 = f3;
            imm_src_d = 3'b001; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OpBranch: begin
            // ALU forms the PC-relative target; the comparator is outside this block.
            ctrl_d.branch = 1'b1; ctrl_d.sel_b = 1'b1;
            imm_src_d = 3'b010; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OpJal: begin
            ctrl_d.reg_wr = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.sel_b = 1'b1;
            imm_src_d = 3'b011;
         end
         OpJalr: begin
            ctrl_d.reg_wr = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.sel_a = 1'b1; ctrl_d.sel_b = 1'b1;
            use_rs1 = 1'b1;
         end
         OpLui: begin
            ctrl_d.reg_wr = 1'b1; ctrl_d.sel_b = 1'b1; ctrl_d.wb_sel = 2'b01;
            ctrl_d.alu_op = ALU_OP_W'(10); imm_src_d = 3'b100;
         end
         OpAuipc: begin
            ctrl_d.reg_wr = 1'b1; ctrl_d.sel_b = 1'b1; ctrl_d.wb_sel = 2'b01; imm_src_d = 3'b100;
         end
         default: known = 1'b0;
      endcase
      ctrl_d.rd  = ctrl_d.reg_wr ? inst_d[7 +: REG_ADDR_W] : '0;
      ctrl_d.rs1 = use_rs1 ? inst_d[15 +: REG_ADDR_W] : '0;
      ctrl_d.rs2 = use_rs2 ? inst_d[20 +: REG_ADDR_W] : '0;
      if (!live_d || !known) begin
         ctrl_d    = '0;
         imm_src_d = 3'b000;
      end else begin
         ctrl_d.valid = 1'b1;
      end
   end

   assign illegal_d = live_d & ~known;

   always_comb begin
      load_use  = ctrl_e.is_load & hits(ctrl_e.valid, ctrl_e.reg_wr, ctrl_e.rd, ctrl_d.rs1,
                                        ctrl_d.rs2);
      // No write-through in the register file, so a W-stage writer still blocks D.
      raw_any   = hits(ctrl_e.valid, ctrl_e.reg_wr, ctrl_e.rd, ctrl_d.rs1, ctrl_d.rs2) |
                  hits(ctrl_m.valid, ctrl_m.reg_wr, ctrl_m.rd, ctrl_d.rs1, ctrl_d.rs2) |
                  hits(ctrl_w.valid, ctrl_w.reg_wr, ctrl_w.rd, ctrl_d.rs1, ctrl_d.rs2);
      stall_raw = ENABLE_FORWARDING ? load_use : raw_any;
      pc_src_e  = ctrl_e.valid & (ctrl_e.jump | (ctrl_e.branch & br_taken_e));
      stall_f   = stall_raw & ~pc_src_e;
      stall_d   = stall_raw & ~pc_src_e;
      flush_d   = pc_src_e;
      flush_e   = pc_src_e | stall_raw;
      fwd_a_e   = ENABLE_FORWARDING ? fwd_sel(ctrl_e.rs1, ctrl_m, ctrl_w) : 2'b00;
      fwd_b_e   = ENABLE_FORWARDING ? fwd_sel(ctrl_e.rs2, ctrl_m, ctrl_w) : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_e <= '0;
         ctrl_m <= '0;
         ctrl_w <= '0;
      end else begin
         ctrl_e <= flush_e ? '0 : ctrl_d;
         ctrl_m <= '{valid: ctrl_e.valid, reg_wr: ctrl_e.reg_wr, mem_wr: ctrl_e.mem_wr,
                     wb_sel: ctrl_e.wb_sel, funct3: ctrl_e.funct3, rd: ctrl_e.rd};
         ctrl_w <= '{valid: ctrl_m.valid, reg_wr: ctrl_m.reg_wr, wb_sel: ctrl_m.wb_sel,
                     rd: ctrl_m.rd};
      end
   end

   assign alu_op_e = ctrl_e.alu_op;
   assign sel_a_e  = ctrl_e.sel_a;
   assign sel_b_e  = ctrl_e.sel_b;
   assign mem_wr_m = ctrl_m.mem_wr;
   assign funct3_m = ctrl_m.funct3;
   assign reg_wr_w = ctrl_w.reg_wr;
   assign wb_sel_w = ctrl_w.wb_sel;
   assign rd_w     = ctrl_w.rd;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench: one forwarding instance and one stall-only instance on shared inputs.
`timescale 1ns / 1ps

module tb_pipelined_controller;

   localparam logic [31:0] InstAdd3  = 32'h002081B3; // add x3,x1,x2
   localparam logic [31:0] InstSub   = 32'h40118233; // sub x4,x3,x1
   localparam logic [31:0] InstNop   = 32'h00000013;
   localparam logic [31:0] InstLw    = 32'h0000A283; // lw x5,0(x1)
   localparam logic [31:0] InstAdd6  = 32'h00028333; // add x6,x5,x0
   localparam logic [31:0] InstBeq   = 32'h00208463; // beq x1,x2,8
   localparam logic [31:0] InstAddi0 = 32'h00508013; // addi x0,x1,5
   localparam logic [31:0] InstAdd7  = 32'h000003B3; // add x7,x0,x0
   localparam logic [31:0] InstSw    = 32'h0070A023; // sw x7,0(x1)
   localparam logic [31:0] InstLui   = 32'h12345437; // lui x8,0x12345
   localparam logic [31:0] InstIll   = 32'hFFFFFFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid_d, br_taken_e;
   logic [31:0] inst_d;

   logic [2:0] imm1, imm0, f3m1, f3m0;
   logic [4:0] alu1, alu0, rdw1, rdw0;
   logic [1:0] fa1, fa0, fb1, fb0, wb1, wb0;
   logic       ill1, ill0, sa1, sa0, sb1, sb0, pcs1, pcs0, mw1, mw0, rw1, rw0;
   logic       sf1, sf0, sd1, sd0, fd1, fd0;

   pipelined_controller #(.ENABLE_FORWARDING(1'b1), .REG_ADDR_W(5), .ALU_OP_W(5)) dut_fwd (
      .clk(clk), .rst(rst), .inst_d(inst_d), .valid_d(valid_d), .br_taken_e(br_taken_e),
      .imm_src_d(imm1), .illegal_d(ill1), .alu_op_e(alu1), .sel_a_e(sa1), .sel_b_e(sb1),
      .fwd_a_e(fa1), .fwd_b_e(fb1), .pc_src_e(pcs1), .mem_wr_m(mw1), .funct3_m(f3m1),
      .reg_wr_w(rw1), .wb_sel_w(wb1), .rd_w(rdw1), .stall_f(sf1), .stall_d(sd1), .flush_d(fd1)
   );

   pipelined_controller #(.ENABLE_FORWARDING(1'b0), .REG_ADDR_W(5), .ALU_OP_W(5)) dut_stl (
      .clk(clk), .rst(rst), .inst_d(inst_d), .valid_d(valid_d), .br_taken_e(br_taken_e),
      .imm_src_d(imm0), .illegal_d(ill0), .alu_op_e(alu0), .sel_a_e(sa0), .sel_b_e(sb0),
      .fwd_a_e(fa0), .fwd_b_e(fb0), .pc_src_e(pcs0), .mem_wr_m(mw0), .funct3_m(f3m0),
      .reg_wr_w(rw0), .wb_sel_w(wb0), .rd_w(rdw0), .stall_f(sf0), .stall_d(sd0), .flush_d(fd0)
   );

   typedef struct {
      logic        rst;
      logic [31:0] inst;
      logic        vld;
      logic        bt;
      logic        ill;
      logic [2:0]  imm;
      logic [4:0]  alu;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        pcs;
      logic        stl;
      logic        fld;
      logic        mwm;
      logic [2:0]  f3m;
      logic        rww;
      logic [4:0]  rdw;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input int r, input logic [31:0] i, input int vl, input int bt,
                               input int ill, input int imm, input int alu, input int fa,
                               input int fb, input int pcs, input int stl, input int fld,
                               input int mwm, input int f3m, input int rww, input int rdw);
      vec_t v;
      v.rst = 1'(r);     v.inst = i;        v.vld = 1'(vl);    v.bt = 1'(bt);
      v.ill = 1'(ill);   v.imm = 3'(imm);   v.alu = 5'(alu);   v.fa = 2'(fa);
      v.fb = 2'(fb);     v.pcs = 1'(pcs);   v.stl = 1'(stl);   v.fld = 1'(fld);
      v.mwm = 1'(mwm);   v.f3m = 3'(f3m);   v.rww = 1'(rww);   v.rdw = 5'(rdw);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] i, input logic vl, input logic bt);
      rst = r; inst_d = i; valid_d = vl; br_taken_e = bt;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset hold, then scenario 2 (fwd from M / from W), 3 (load-use), 4 (taken branch,
      // squashed slots, not-taken), 5 (x0, store fwd, illegal), then reset mid-stream
      vq.push_back(mk(1, InstIll,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 0
      vq.push_back(mk(1, InstIll,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstAdd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 5
      vq.push_back(mk(0, InstSub,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstNop,  1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstAdd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
      vq.push_back(mk(0, InstNop,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4));
      vq.push_back(mk(0, InstSub,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // 10
      vq.push_back(mk(0, InstLw,   1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3));
      vq.push_back(mk(0, InstAdd6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, InstAdd6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 4));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 5));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 15
      vq.push_back(mk(0, InstLw,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6));
      vq.push_back(mk(0, InstBeq,  1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstAdd6, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0));
      vq.push_back(mk(0, 32'h0,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 20
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstBeq,  1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstAdd7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstAddi0,1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstAdd7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 25
      vq.push_back(mk(0, InstSw,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
      vq.push_back(mk(0, InstIll,  1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 7));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 30
      vq.push_back(mk(0, InstAdd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, InstSw,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(1, InstAdd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 35
      vq.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      rst = 1'b1; inst_d = InstIll; valid_d = 1'b1; br_taken_e = 1'b1;
      adv();

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst, vq[i].inst, vq[i].vld, vq[i].bt);
         chk($sformatf("r%0d illegal_d", i), int'(ill1), int'(vq[i].ill));
         chk($sformatf("r%0d imm_src_d", i), int'(imm1), int'(vq[i].imm));
         chk($sformatf("r%0d alu_op_e", i), int'(alu1), int'(vq[i].alu));
         chk($sformatf("r%0d fwd_a_e", i), int'(fa1), int'(vq[i].fa));
         chk($sformatf("r%0d fwd_b_e", i), int'(fb1), int'(vq[i].fb));
         chk($sformatf("r%0d pc_src_e", i), int'(pcs1), int'(vq[i].pcs));
         chk($sformatf("r%0d stall_f", i), int'(sf1), int'(vq[i].stl));
         chk($sformatf("r%0d stall_d", i), int'(sd1), int'(vq[i].stl));
         chk($sformatf("r%0d flush_d", i), int'(fd1), int'(vq[i].fld));
         chk($sformatf("r%0d mem_wr_m", i), int'(mw1), int'(vq[i].mwm));
         chk($sformatf("r%0d funct3_m", i), int'(f3m1), int'(vq[i].f3m));
         chk($sformatf("r%0d reg_wr_w", i), int'(rw1), int'(vq[i].rww));
         chk($sformatf("r%0d rd_w", i), int'(rdw1), int'(vq[i].rdw));
         adv();
      end

      // LUI through the pipe: U immediate, LUI alu op, B=imm, W selects ALU result
      drive(1'b0, InstLui, 1'b1, 1'b0);
      chk("lui imm_src_d", int'(imm1), 4);
      adv();
      drive(1'b0, InstAdd3, 1'b1, 1'b0);
      chk("lui alu_op_e", int'(alu1), 10);
      chk("lui sel_b_e", int'(sb1), 1);
      adv();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("add sel_a_e", int'(sa1), 1);
      chk("add sel_b_e", int'(sb1), 0);
      adv();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("lui wb_sel_w", int'(wb1), 1);
      chk("lui rd_w", int'(rdw1), 8);
      adv();

      // stall-only instance: add x3 then sub reading x3 stalls while add sits in E, M, W
      drive(1'b1, 32'h0, 1'b0, 1'b0);
      adv();
      drive(1'b0, InstAdd3, 1'b1, 1'b0);
      chk("s6 c0 stall_d", int'(sd0), 0);
      adv();
      for (int c = 1; c <= 3; c++) begin
         drive(1'b0, InstSub, 1'b1, 1'b0);
         chk($sformatf("s6 c%0d stall_d", c), int'(sd0), 1);
         chk($sformatf("s6 c%0d stall_f", c), int'(sf0), 1);
         chk($sformatf("s6 c%0d fwd_a_e", c), int'(fa0), 0);
         chk($sformatf("s6 c%0d fwd_b_e", c), int'(fb0), 0);
         adv();
      end
      drive(1'b0, InstSub, 1'b1, 1'b0);
      chk("s6 c4 stall_d", int'(sd0), 0);
      chk("s6 c4 alu_op_e", int'(alu0), 0);
      adv();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("s6 c5 alu_op_e", int'(alu0), 1);
      chk("s6 c5 fwd_a_e", int'(fa0), 0);
      chk("s6 c5 fwd_b_e", int'(fb0), 0);
      adv();

      // stall-only instance: taken beq in E while D has a RAW match on lw in M
      drive(1'b1, 32'h0, 1'b0, 1'b0);
      adv();
      drive(1'b0, InstLw, 1'b1, 1'b0);
      adv();
      drive(1'b0, InstBeq, 1'b1, 1'b0);
      chk("prio c1 stall_d", int'(sd0), 0);
      adv();
      drive(1'b0, InstAdd6, 1'b1, 1'b1);
      chk("prio pc_src_e", int'(pcs0), 1);
      chk("prio flush_d", int'(fd0), 1);
      chk("prio stall_f", int'(sf0), 0);
      chk("prio stall_d", int'(sd0), 0);
      adv();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("prio c3 pc_src_e", int'(pcs0), 0);
      chk("prio c3 reg_wr_w", int'(rw0), 1);
      chk("prio c3 rd_w", int'(rdw0), 5);
      adv();
      for (int c = 4; c <= 6; c++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0);
         chk($sformatf("prio c%0d reg_wr_w", c), int'(rw0), 0);
         chk($sformatf("prio c%0d mem_wr_m", c), int'(mw0), 0);
         adv();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
